// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: decode hazards, iterative divider,
// memory wait states and exception/eret redirect toward IF.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// ST_RUN      | normal flow; only combinational hazards apply
// ST_DIV      | iterative divide occupies EX; cnt counts down to the final cycle
// ST_REDIR    | exception/eret taken while a fetch was outstanding; pend_pc waits for IF

module pipe_hazard_ctrl #(
    parameter int          DIV_CYCLES = 32,
    parameter int          CNT_W      = 6,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  id_rs_i,
    input  logic [4:0]  id_rt_i,
    input  logic        ex_rmem_i,
    input  logic [4:0]  ex_waddr_i,
    input  logic        id_branch_stall_i,
    input  logic        ex_div_start_i,
    input  logic        imem_busy_i,
    input  logic        dmem_busy_i,
    input  logic        mem_excep_i,
    input  logic        mem_eret_i,
    input  logic [31:0] cp0_epc_i,
    output logic        if_stall_o,
    output logic        id_stall_o,
    output logic        ex_stall_o,
    output logic        mem_stall_o,
    output logic        wb_stall_o,
    output logic        id_flush_o,
    output logic        ex_flush_o,
    output logic        mem_flush_o,
    output logic        wb_flush_o,
    output logic        pc_redirect_o,
    output logic [31:0] redirect_pc_o,
    output logic        div_busy_o,
    output logic        div_done_o
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DIV   = 2'd1,
        ST_REDIR = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(DIV_CYCLES - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [31:0]       pend_pc, pend_pc_nxt;

    // bit 0 = IF ... bit 4 = WB
    logic [4:0]        stall_v, flush_v;
    logic              redirect, div_busy, div_done;
    logic [31:0]       redirect_pc;
    logic              load_use, exc_take, div_start_ok;
    logic [31:0]       exc_target;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= ST_RUN;
            cnt     <= '0;
            pend_pc <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            pend_pc <= pend_pc_nxt;
        end
    end

    always_comb begin
        stall_v      = '0;
        flush_v      = '0;
        redirect     = 1'b0;
        redirect_pc  = '0;
        div_busy     = 1'b0;
        div_done     = 1'b0;
        state_nxt    = state;
        cnt_nxt      = cnt;
        pend_pc_nxt  = pend_pc;

        load_use     = ex_rmem_i && (ex_waddr_i != 5'd0) &&
                       ((ex_waddr_i == id_rs_i) || (ex_waddr_i == id_rt_i));
        exc_take     = mem_excep_i || mem_eret_i;
        exc_target   = mem_eret_i ? cp0_epc_i : EXC_VECTOR;
        div_start_ok = (state == ST_RUN) && ex_div_start_i;

        if (exc_take) begin
            flush_v     = 5'b11110;
            redirect    = !imem_busy_i;
            redirect_pc = exc_target;
            cnt_nxt     = '0;
            if (imem_busy_i) begin
                pend_pc_nxt = exc_target;
                state_nxt   = ST_REDIR;
            end else begin
                state_nxt   = ST_RUN;
            end
        end else begin
            if (state == ST_REDIR) begin
                redirect_pc = pend_pc;
            end

            if (dmem_busy_i) begin
                stall_v = 5'b01111;
                flush_v = 5'b10000;
                // Counter keeps running under a data stall but parks on its last
                // count so the HI/LO write is not lost while EX is held.
                if (state == ST_DIV) begin
                    div_busy = 1'b1;
                    if (cnt > CNT_ONE) begin
                        cnt_nxt = cnt - CNT_ONE;
                    end
                end
            end else if (div_start_ok || ((state == ST_DIV) && (cnt != CNT_ONE))) begin
                stall_v   = 5'b00111;
                flush_v   = 5'b01000;
                div_busy  = 1'b1;
                state_nxt = ST_DIV;
                cnt_nxt   = div_start_ok ? CNT_START : (cnt - CNT_ONE);
            end else begin
                if (state == ST_DIV) begin
                    div_busy  = 1'b1;
                    div_done  = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = ST_RUN;
                end
                if (load_use || id_branch_stall_i) begin
                    stall_v = 5'b00011;
                    flush_v = 5'b00100;
                end else if (imem_busy_i) begin
                    stall_v = 5'b00001;
                    flush_v = 5'b00010;
                end else if (state == ST_REDIR) begin
                    // Fetch finally done: discard it and steer IF to the saved target.
                    flush_v   = 5'b00010;
                    redirect  = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
        end
    end

    // While reset is held the outputs show the reset pattern regardless of inputs.
    assign if_stall_o    = rst_i & stall_v[0] & ~flush_v[0];
    assign id_stall_o    = rst_i & stall_v[1] & ~flush_v[1];
    assign ex_stall_o    = rst_i & stall_v[2] & ~flush_v[2];
    assign mem_stall_o   = rst_i & stall_v[3] & ~flush_v[3];
    assign wb_stall_o    = rst_i & stall_v[4] & ~flush_v[4];
    assign id_flush_o    = ~rst_i | flush_v[1];
    assign ex_flush_o    = ~rst_i | flush_v[2];
    assign mem_flush_o   = ~rst_i | flush_v[3];
    assign wb_flush_o    = ~rst_i | flush_v[4];
    assign pc_redirect_o = rst_i & redirect;
    assign redirect_pc_o = rst_i ? redirect_pc : 32'd0;
    assign div_busy_o    = rst_i & div_busy;
    assign div_done_o    = rst_i & div_done;

endmodule
